// File: rtl/register_file_wrapper_if.sv
// Register file bus: decode-side read addresses, write-back port and read data.
interface register_file_wrapper_if #(
   parameter int WIDTH = 32,
   parameter int SIZE  = 5
);
   logic             reg_write_i;
   logic [SIZE-1:0]  write_register_i;
   logic [SIZE-1:0]  read_register_1_i;
   logic [SIZE-1:0]  read_register_2_i;
   logic [WIDTH-1:0] write_data_i;
   logic [WIDTH-1:0] read_data_1_o;
   logic [WIDTH-1:0] read_data_2_o;

   // Datapath side: presents addresses and write data, consumes read data.
   modport master (
      output reg_write_i, write_register_i, read_register_1_i, read_register_2_i, write_data_i,
      input  read_data_1_o, read_data_2_o
   );

   // Register file side.
   modport slave (
      input  reg_write_i, write_register_i, read_register_1_i, read_register_2_i, write_data_i,
      output read_data_1_o, read_data_2_o
   );
endinterface

// File: rtl/register_file_wrapper.sv
// Two-read / one-write register file built from a write decoder, per-register
// enabled flops and two combinational read muxes. R0 has no storage and reads 0.

// One storage register: loads d when en is high, cleared asynchronously.
module register_file_cell #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   // Enabled flop with asynchronous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)   q <= '0;
      else if (en) q <= d;
   end
endmodule

module register_file_wrapper #(
   parameter int WIDTH = 32,
   parameter int SIZE  = 5
) (
   input  logic                   clk,
   input  logic                   reset,
   register_file_wrapper_if.slave bus
);
   localparam int NUM_REGS = 1 << SIZE;

   // Decode starts at index 1: R0 never gets an enable, so writes to it vanish.
   logic [NUM_REGS-1:1] wr_en;
   logic [WIDTH-1:0]    regs [NUM_REGS];

   assign regs[0] = '0;

   genvar i;
   generate
      for (i = 1; i < NUM_REGS; i++) begin : g_reg
         assign wr_en[i] = bus.reg_write_i && (bus.write_register_i == SIZE'(i));

         register_file_cell #(.WIDTH(WIDTH)) u_cell (
            .clk   (clk),
            .reset (reset),
            .en    (wr_en[i]),
            .d     (bus.write_data_i),
            .q     (regs[i])
         );
      end
   endgenerate

   // Read ports are pure muxes; no bypass, so a same-cycle write shows after the edge.
   assign bus.read_data_1_o = regs[bus.read_register_1_i];
   assign bus.read_data_2_o = regs[bus.read_register_2_i];
endmodule

// File: tb/tb_register_file_wrapper.sv
// Directed bench for register_file_wrapper: reset, writes, R0, disable, same-address, async reset.
module tb_register_file_wrapper;
   localparam int WIDTH = 32;
   localparam int SIZE  = 5;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   register_file_wrapper_if #(.WIDTH(WIDTH), .SIZE(SIZE)) bus ();

   register_file_wrapper #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   // Drive one write, let the rising edge commit it, then drop the enable.
   task automatic write_reg(input logic [SIZE-1:0] addr, input logic [WIDTH-1:0] data);
      bus.reg_write_i      = 1'b1;
      bus.write_register_i = addr;
      bus.write_data_i     = data;
      @(posedge clk); #1;
      bus.reg_write_i      = 1'b0;
   endtask

   task automatic test_reset;
      // Fill some registers, then assert reset between edges.
      write_reg(5'd3, 32'hDEAD_BEEF);
      write_reg(5'd31, 32'h1234_5678);
      #2 reset = 1'b1;
      #1;
      for (int a = 0; a < (1 << SIZE); a++) begin
         bus.read_register_1_i = SIZE'(a);
         bus.read_register_2_i = SIZE'((1 << SIZE) - 1 - a);
         #1;
         checks++;
         if (bus.read_data_1_o !== '0 || bus.read_data_2_o !== '0) begin
            errors++;
            $display("FAIL reset_clear a=%0d p1=%h p2=%h exp 0", a, bus.read_data_1_o, bus.read_data_2_o);
         end
      end
      @(negedge clk) reset = 1'b0;
      #1;
   endtask

   task automatic test_basic_write;
      write_reg(5'd2, 32'd7);
      write_reg(5'd4, 32'd20);
      write_reg(5'd31, 32'd6);
      write_reg(5'd19, 32'd78);
      bus.read_register_2_i = 5'd19;
      bus.read_register_1_i = 5'd2;  #1;
      checks++;
      if (bus.read_data_1_o !== 32'd7) begin
         errors++; $display("FAIL basic_r2 got %0d exp 7", bus.read_data_1_o);
      end
      bus.read_register_1_i = 5'd4;  #1;
      checks++;
      if (bus.read_data_1_o !== 32'd20) begin
         errors++; $display("FAIL basic_r4 got %0d exp 20", bus.read_data_1_o);
      end
      bus.read_register_1_i = 5'd31; #1;
      checks++;
      if (bus.read_data_1_o !== 32'd6) begin
         errors++; $display("FAIL basic_r31 got %0d exp 6", bus.read_data_1_o);
      end
      checks++;
      if (bus.read_data_2_o !== 32'd78) begin
         errors++; $display("FAIL basic_r19 got %0d exp 78", bus.read_data_2_o);
      end
   endtask

   task automatic test_r0;
      write_reg(5'd0, 32'd3);
      bus.read_register_1_i = 5'd0;
      bus.read_register_2_i = 5'd0;
      #1;
      checks++;
      if (bus.read_data_1_o !== '0 || bus.read_data_2_o !== '0) begin
         errors++; $display("FAIL r0_write p1=%h p2=%h exp 0", bus.read_data_1_o, bus.read_data_2_o);
      end
   endtask

   task automatic test_write_disable;
      bus.reg_write_i      = 1'b0;
      bus.write_register_i = 5'd2;
      bus.write_data_i     = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      bus.read_register_1_i = 5'd2; #1;
      checks++;
      if (bus.read_data_1_o !== 32'd7) begin
         errors++; $display("FAIL write_disable got %h exp 7", bus.read_data_1_o);
      end
   endtask

   task automatic test_same_address;
      bus.read_register_1_i = 5'd4;
      bus.read_register_2_i = 5'd4;
      #1;
      checks++;
      if (bus.read_data_1_o !== 32'd20 || bus.read_data_2_o !== 32'd20) begin
         errors++; $display("FAIL dual_r4 p1=%0d p2=%0d exp 20", bus.read_data_1_o, bus.read_data_2_o);
      end
      bus.reg_write_i      = 1'b1;
      bus.write_register_i = 5'd4;
      bus.write_data_i     = 32'h55;
      #1;
      checks++;
      if (bus.read_data_1_o !== 32'd20 || bus.read_data_2_o !== 32'd20) begin
         errors++; $display("FAIL no_bypass p1=%h p2=%h exp 14", bus.read_data_1_o, bus.read_data_2_o);
      end
      @(posedge clk); #1;
      bus.reg_write_i = 1'b0;
      checks++;
      if (bus.read_data_1_o !== 32'h55 || bus.read_data_2_o !== 32'h55) begin
         errors++; $display("FAIL same_addr_commit p1=%h p2=%h exp 55", bus.read_data_1_o, bus.read_data_2_o);
      end
   endtask

   task automatic test_async_reset;
      bus.read_register_1_i = 5'd2;
      bus.read_register_2_i = 5'd19;
      #1;
      checks++;
      if (bus.read_data_1_o !== 32'd7 || bus.read_data_2_o !== 32'd78) begin
         errors++; $display("FAIL pre_reset p1=%0d p2=%0d exp 7/78", bus.read_data_1_o, bus.read_data_2_o);
      end
      // Mid-cycle assertion: outputs must clear before any edge.
      #1 reset = 1'b1;
      #1;
      checks++;
      if (bus.read_data_1_o !== '0 || bus.read_data_2_o !== '0) begin
         errors++; $display("FAIL async_reset p1=%h p2=%h exp 0", bus.read_data_1_o, bus.read_data_2_o);
      end
      // Writes attempted during reset are blocked.
      bus.read_register_1_i = 5'd5;
      write_reg(5'd5, 32'hAA);
      checks++;
      if (bus.read_data_1_o !== '0) begin
         errors++; $display("FAIL write_in_reset got %h exp 0", bus.read_data_1_o);
      end
      @(negedge clk) reset = 1'b0;
      bus.read_register_1_i = 5'd2;
      write_reg(5'd2, 32'd9);
      checks++;
      if (bus.read_data_1_o !== 32'd9) begin
         errors++; $display("FAIL post_reset_write got %0d exp 9", bus.read_data_1_o);
      end
      checks++;
      if (bus.read_data_2_o !== '0) begin
         errors++; $display("FAIL post_reset_r19 got %0d exp 0", bus.read_data_2_o);
      end
   endtask

   task automatic test_back_to_back;
      bus.read_register_1_i = 5'd10;
      bus.read_register_2_i = 5'd11;
      write_reg(5'd10, 32'hA5A5_0001);
      write_reg(5'd11, 32'h5A5A_0002);
      write_reg(5'd10, 32'hCAFE_0003);
      checks++;
      if (bus.read_data_1_o !== 32'hCAFE_0003 || bus.read_data_2_o !== 32'h5A5A_0002) begin
         errors++; $display("FAIL back_to_back p1=%h p2=%h exp cafe0003/5a5a0002",
                            bus.read_data_1_o, bus.read_data_2_o);
      end
   endtask

   initial begin
      reset                 = 1'b1;
      bus.reg_write_i       = 1'b0;
      bus.write_register_i  = '0;
      bus.read_register_1_i = '0;
      bus.read_register_2_i = '0;
      bus.write_data_i      = '0;
      #12;
      checks++;
      if (bus.read_data_1_o !== '0 || bus.read_data_2_o !== '0) begin
         errors++; $display("FAIL power_on p1=%h p2=%h exp 0", bus.read_data_1_o, bus.read_data_2_o);
      end
      @(negedge clk) reset = 1'b0;
      #1;
      test_reset();
      test_basic_write();
      test_r0();
      test_write_disable();
      test_same_address();
      test_async_reset();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/register_file_wrapper.md
# register_file_wrapper

Two-read, one-write general-purpose register file for the 32-bit MIPS-style datapath. It holds 2^SIZE registers of WIDTH bits and sits between instruction decode (read addresses) and write-back (write address and data). It is built structurally: a write-address decoder, per-register enabled flops and two read multiplexers. Register 0 is hardwired to zero.

## Interface
Parameters:
- WIDTH, 32, data width of every register and data port
- SIZE, 5, address width; register count = 2^SIZE (32)

Ports:
- clk  input  1  single system clock; all writes on rising edge
- reset  input  1  asynchronous, active-high; clears every register to 0
- reg_write_i  input  1  write enable, sampled on rising clk
- write_register_i  input  SIZE  destination register index
- read_register_1_i  input  SIZE  index for read port 1
- read_register_2_i  input  SIZE  index for read port 2
- write_data_i  input  WIDTH  data to be written
- read_data_1_o  output  WIDTH  contents of register read_register_1_i
- read_data_2_o  output  WIDTH  contents of register read_register_2_i

## Operation
- Storage: registers R0..R(2^SIZE−1), each WIDTH bits.
- Write: on rising clk, if reg_write_i=1 and reset=0, R[write_register_i] <= write_data_i. One register written per cycle at most.
- reg_write_i=0: no register changes.
- R0: writes to index 0 are ignored; R0 always reads 0.
- Decoder: one-hot enable from write_register_i, gated by reg_write_i; bit 0 of the decode is never asserted.
- Read: purely combinational. read_data_1_o = R[read_register_1_i], read_data_2_o = R[read_register_2_i]. The two ports are independent and may address the same register.
- Reset: asserting reset immediately clears R1..R(2^SIZE−1) to 0, regardless of clk. Both outputs then read 0 within combinational delay. While reset is high, writes are blocked.
- No internal write-to-read bypass. A read of the register being written returns the old value until the rising edge that commits the write, then the new value.
- Indices are always in range, because 2^SIZE covers the full address space.

## Timing
- Write latency: data presented before rising edge N is visible on the read ports immediately after edge N, after combinational settle. There are no extra pipeline stages.
- Read latency: 0 cycles; outputs follow address or storage changes combinationally.
- reset is asynchronous on assertion. Deassertion is sampled normally: the first write can occur on the first rising edge where reset=0.
- Reset mid-operation: an in-flight write on the same edge as reset assertion is lost; all registers read 0.
- Simultaneous read and write of the same index in one cycle: old value before the edge, new value after.
- Outputs after reset: read_data_1_o = read_data_2_o = 0 for every address.

## Test plan
- Reset: assert reset with arbitrary prior contents. Read addresses 0..31 on both ports → all read 0, with no clock edge required.
- Basic write/read: write 7→R2, 20→R4, 6→R31, 78→R19 on consecutive edges with reg_write_i=1. Then read port1=R2, R4, R31 and port2=R19 → 7, 20, 6, 78.
- R0 protection: write 3→R0 with reg_write_i=1 → both ports reading index 0 return 0.
- Write disable: preload R2=7, then drive reg_write_i=0 with write_register_i=2, write_data_i=0xFFFFFFFF for one edge → R2 still reads 7.
- Dual-port and same-address: port1=R4, port2=R4 after writing 20 → both read 20. Then present write 0x55 to R4: before the edge both read 20; after the edge both read 0x55.
- Asynchronous reset mid-run: with R2=7 and R19=78, assert reset between clock edges → outputs drop to 0 before the next edge. After deassertion, writing 9→R2 reads back 9 after one edge.
